// File: rtl/life_pkg.sv
// Shared types and constants for the Life-like step engine.
package life_pkg;

    typedef logic [8:0] rule_t;

    localparam rule_t RULE_B_CONWAY   = 9'b000001000;
    localparam rule_t RULE_S_CONWAY   = 9'b000001100;
    localparam rule_t RULE_B_HIGHLIFE = 9'b001001000;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Flat bit index of cell (r,c) on a board w cells wide.
    function automatic int cell_idx(input int r, input int c, input int w);
        return r * w + c;
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state for one board row from its three source rows.
module life_row_eval
    import life_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] above,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] below,
    input  rule_t        B,
    input  rule_t        S,
    input  logic         edge_wrap,
    output logic [W-1:0] next_row
);

    for (genvar c = 0; c < W; c++) begin : g_col
        // Column neighbours wrap around; in dead mode the edge columns are masked off.
        localparam int CL = (c == 0) ? W - 1 : c - 1;
        localparam int CR = (c == W - 1) ? 0 : c + 1;

        logic       l_ok;
        logic       r_ok;
        logic [3:0] n;

        assign l_ok = (c != 0) || edge_wrap;
        assign r_ok = (c != W - 1) || edge_wrap;

        assign n = 4'(above[c]) + 4'(below[c])
                 + 4'(l_ok & above[CL]) + 4'(l_ok & cur[CL]) + 4'(l_ok & below[CL])
                 + 4'(r_ok & above[CR]) + 4'(r_ok & cur[CR]) + 4'(r_ok & below[CR]);

        assign next_row[c] = cur[c] ? S[n] : B[n];
    end

endmodule

// File: rtl/life_step_engine.sv
// Row-serial single-generation engine for Life-like rules with start/busy/done handshake.
module life_step_engine
    import life_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int H  = 24,
    localparam int L  = W * H,
    parameter  int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          edge_wrap,
    input  rule_t         B,
    input  rule_t         S,
    input  logic [L-1:0]  board_in,
    output logic [L-1:0]  board_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] gen_count,
    output logic          stable,
    output logic          extinct
);

    localparam int           RW       = (H > 1) ? $clog2(H) : 1;
    localparam logic [L-1:0] ROW_MASK = L'({W{1'b1}});

    state_t         state;
    state_t         state_nx;
    logic [L-1:0]   src;
    logic [L-1:0]   dst;
    logic [RW-1:0]  row;
    rule_t          b_q;
    rule_t          s_q;
    logic           wrap_q;

    logic           accept;
    logic           eval;
    logic           finish;
    logic           last_row;
    int             row_base;
    logic [W-1:0]   row_above;
    logic [W-1:0]   row_cur;
    logic [W-1:0]   row_below;
    logic [W-1:0]   row_next;

    assign last_row = (row == RW'(H - 1));
    assign row_base = cell_idx(int'(row), 0, W);

    // NOTE: non-blocking assignments for every register so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_row) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && start;
        eval   = (state == RUN);
        finish = (state == FIN);
        busy   = eval;
    end

    // NOTE: every output gets a default before the branches, otherwise the mux infers latches.
    always_comb begin
        row_above = '0;
        row_below = '0;
        row_cur   = W'(src >> row_base);
        if (row != '0)  row_above = W'(src >> cell_idx(int'(row) - 1, 0, W));
        else if (wrap_q) row_above = W'(src >> cell_idx(H - 1, 0, W));
        if (!last_row)  row_below = W'(src >> cell_idx(int'(row) + 1, 0, W));
        else if (wrap_q) row_below = src[W-1:0];
    end

    life_row_eval #(.W(W)) u_row_eval (
        .above    (row_above),
        .cur      (row_cur),
        .below    (row_below),
        .B        (b_q),
        .S        (s_q),
        .edge_wrap(wrap_q),
        .next_row (row_next)
    );

    // NOTE: the src/dst board registers are reset as well, so nothing stale survives an aborted step.
    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= '0;
            dst       <= '0;
            row       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            wrap_q    <= 1'b0;
            board_out <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                src    <= board_in;
                b_q    <= B;
                s_q    <= S;
                wrap_q <= edge_wrap;
                row    <= '0;
            end
            if (eval) begin
                dst <= (dst & ~(ROW_MASK << row_base)) | (L'(row_next) << row_base);
                if (!last_row) row <= row + 1'b1;
            end
            if (finish) begin
                board_out <= dst;
                gen_count <= gen_count + 1'b1;
                stable    <= (dst == src);
                extinct   <= (dst == '0);
            end
        end
    end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed self-checking bench: a 5x5 engine for the blinker and an 8x8 engine for the rest.
module tb_life_step_engine;
    import life_pkg::*;

    localparam int W5 = 5, H5 = 5, L5 = 25;
    localparam int W8 = 8, H8 = 8, L8 = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          st5, wrap5, busy5, done5, stable5, ext5;
    rule_t         b5, s5;
    logic [L5-1:0] bin5, bout5;
    logic [15:0]   gen5;

    logic          st8, wrap8, busy8, done8, stable8, ext8;
    rule_t         b8, s8;
    logic [L8-1:0] bin8, bout8;
    logic [15:0]   gen8;

    life_step_engine #(.W(W5), .H(H5), .CW(16)) u_dut5 (
        .clk(clk), .rst(rst), .start(st5), .edge_wrap(wrap5), .B(b5), .S(s5),
        .board_in(bin5), .board_out(bout5), .busy(busy5), .done(done5),
        .gen_count(gen5), .stable(stable5), .extinct(ext5)
    );

    life_step_engine #(.W(W8), .H(H8), .CW(16)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .edge_wrap(wrap8), .B(b8), .S(s8),
        .board_in(bin8), .board_out(bout8), .busy(busy8), .done(done8),
        .gen_count(gen8), .stable(stable8), .extinct(ext8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] put(input logic [63:0] b, input int w, input int r, input int c);
        logic [63:0] one;
        one = 64'd1;
        return b | (one << cell_idx(r, c, w));
    endfunction

    task automatic step5(input logic [L5-1:0] brd, input rule_t bb, input rule_t ss, input logic wr);
        int lat;
        @(negedge clk);
        bin5 = brd; b5 = bb; s5 = ss; wrap5 = wr; st5 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st5 = 1'b0;
        check("busy5_after_accept", busy5, 1);
        lat = 0;
        while (!done5 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done5_seen", done5, 1);
        check("latency5", lat, H5 + 1);
    endtask

    task automatic step8(input logic [L8-1:0] brd, input rule_t bb, input rule_t ss, input logic wr,
                         input logic corrupt);
        int lat;
        @(negedge clk);
        bin8 = brd; b8 = bb; s8 = ss; wrap8 = wr; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        if (corrupt) bin8 = '1;
        check("busy8_after_accept", busy8, 1);
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done8_seen", done8, 1);
        check("latency8", lat, H8 + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] hb, vb, g0, gw, gd, blk, one, cur;
        int dones, last, interval, overlap, seen;

        rst = 1'b1;
        st5 = 0; wrap5 = 0; b5 = '0; s5 = '0; bin5 = '0;
        st8 = 0; wrap8 = 0; b8 = '0; s8 = '0; bin8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_board5", bout5, 0);
        check("rst_gen5", gen5, 0);
        check("rst_busy5", busy5, 0);
        check("rst_done5", done5, 0);
        check("rst_board8", bout8, 0);
        check("rst_gen8", gen8, 0);
        check("rst_stable8", stable8, 0);
        check("rst_extinct8", ext8, 0);

        // Blinker on the 5x5 torus
        hb = put(put(put(64'd0, W5, 2, 1), W5, 2, 2), W5, 2, 3);
        vb = put(put(put(64'd0, W5, 1, 2), W5, 2, 2), W5, 3, 2);
        step5(hb[L5-1:0], RULE_B_CONWAY, RULE_S_CONWAY, 1'b1);
        check("blink1_board", bout5, vb);
        check("blink1_stable", stable5, 0);
        check("blink1_extinct", ext5, 0);
        check("blink1_gen", gen5, 1);
        step5(bout5, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1);
        check("blink2_board", bout5, hb);
        check("blink2_gen", gen5, 2);

        // Glider in the bottom-right corner, 4 generations
        g0 = put(put(put(put(put(64'd0, W8, 5, 6), W8, 6, 7), W8, 7, 5), W8, 7, 6), W8, 7, 7);
        gw = put(put(put(put(put(64'd0, W8, 6, 7), W8, 7, 0), W8, 0, 6), W8, 0, 7), W8, 0, 0);
        gd = put(put(put(put(64'd0, W8, 6, 6), W8, 6, 7), W8, 7, 6), W8, 7, 7);
        cur = g0;
        for (int i = 0; i < 4; i++) begin
            step8(cur, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1, 1'b0);
            cur = bout8;
        end
        check("glider_wrap_board", bout8, gw);
        check("glider_wrap_gen", gen8, 4);
        cur = g0;
        for (int i = 0; i < 4; i++) begin
            step8(cur, RULE_B_CONWAY, RULE_S_CONWAY, 1'b0, 1'b0);
            cur = bout8;
        end
        check("glider_dead_board", bout8, gd);
        check("glider_dead_gen", gen8, 8);

        // Still life and extinction
        blk = put(put(put(put(64'd0, W8, 3, 3), W8, 3, 4), W8, 4, 3), W8, 4, 4);
        step8(blk, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1, 1'b0);
        check("block_board", bout8, blk);
        check("block_stable", stable8, 1);
        check("block_extinct", ext8, 0);
        one = put(64'd0, W8, 2, 2);
        step8(one, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1, 1'b0);
        check("single_board", bout8, 0);
        check("single_extinct", ext8, 1);
        check("single_stable", stable8, 0);

        // B0 rule births every cell of an empty board
        step8(64'd0, 9'b000000001, 9'b000000000, 1'b0, 1'b0);
        check("b0_board", bout8, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b0_extinct", ext8, 0);
        check("b0_stable", stable8, 0);
        check("b0_gen", gen8, 11);

        // start held high for 3H cycles
        @(negedge clk);
        bin8 = blk; b8 = RULE_B_CONWAY; s8 = RULE_S_CONWAY; wrap8 = 1'b1; st8 = 1'b1;
        dones = 0; last = -1; interval = 0; overlap = 0;
        for (int cyc = 0; cyc < 3 * H8 + 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 3 * H8 - 1) st8 = 1'b0;
            if (done8) begin
                dones++;
                if (last >= 0) interval = cyc - last;
                last = cyc;
            end
            if (done8 && busy8) overlap++;
        end
        check("hs_done_count", dones, 3);
        check("hs_interval", interval, H8 + 2);
        check("hs_overlap", overlap, 0);
        check("hs_gen", gen8, 14);

        // board_in changes after acceptance must not leak into the step
        step8(blk, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1, 1'b1);
        check("capture_board", bout8, blk);
        check("capture_stable", stable8, 1);

        // Reset while evaluating row 3
        @(negedge clk);
        bin8 = g0; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_board", bout8, 0);
        check("abort_gen", gen8, 0);
        check("abort_busy", busy8, 0);
        seen = 0;
        for (int cyc = 0; cyc < H8 + 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) seen++;
        end
        check("abort_no_done", seen, 0);
        step8(blk, RULE_B_CONWAY, RULE_S_CONWAY, 1'b1, 1'b0);
        check("fresh_board", bout8, blk);
        check("fresh_gen", gen8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
- Parametrised, row-serial successor to the combinational next-state block.
- Computes one generation of an outer-totalistic cellular automaton (Life-like B/S rules) over a W x H board, one row per clock.
- Adds start/busy/done handshake, selectable toroidal or dead-border edges, a full 0..8 rule range, generation counter, and stable/extinct detection.
- Sits between the board register/display path and the step controller.

Parameters:
- W, 32, board width in cells.
- H, 24, board height in cells.
- L, W*H, total cells; derived, never overridden.
- CW, 16, generation counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one generation step; accepted only when not busy.
- edge_wrap  in  1  1 = toroidal edges, 0 = cells outside the board read as dead; sampled at accepted start.
- B  in  9  birth mask; bit n set means a dead cell with n live neighbours is born; sampled at accepted start.
- S  in  9  survival mask; bit n set means a live cell with n live neighbours survives; sampled at accepted start.
- board_in  in  L  current board, cell (r,c) at bit r*W+c; sampled at accepted start.
- board_out  out  L  last completed generation.
- busy  out  1  high while a step is in progress.
- done  out  1  one-cycle pulse when board_out is updated.
- gen_count  out  CW  number of completed generations since reset.
- stable  out  1  last result equals its source board.
- extinct  out  1  last result has no live cells.

Behaviour:
- Reset, and every cycle rst is high:
  - state IDLE.
  - board_out, gen_count, stable, extinct, busy, done = 0.
  - Internal src/dst/row registers = 0.
  - Reset overrides start in the same cycle.
- States:
  - IDLE: waits for start.
  - RUN: evaluates rows.
  - FIN: single cycle; returns to IDLE.
- Start acceptance:
  - start with state IDLE at edge t: capture board_in into src; capture B, S, edge_wrap; row <= 0; enter RUN.
  - busy is 1 from t+1 through t+H, i.e. during RUN only.
  - start while busy is ignored and not queued. board_in changes after t do not affect the step.
- RUN: each cycle, evaluate row `row` of src into the matching W bits of dst.
  - Neighbour count n is 4 bits, range 0..8, over the 8 surrounding cells.
  - Wrap mode: row-1 of row 0 is H-1; col-1 of col 0 is W-1; symmetric at the far edges.
  - Dead mode: off-board neighbours contribute 0.
  - Next state = (!alive && B[n]) || (alive && S[n]); B[0] and S[0] are honoured.
  - row == H-1 -> FIN; otherwise row++.
- FIN, edge t+H+1:
  - board_out <= dst; done = 1 for exactly this cycle.
  - gen_count <= gen_count+1, wrapping to 0 after 2^CW-1.
  - stable <= (dst == src); extinct <= (dst == 0).
  - Next state IDLE. start in the FIN cycle is ignored; earliest new accept is the following cycle.
- Latency: accepted start at edge t -> done high in the cycle after edge t+H+1; H+1 cycles start-to-done.
- board_out, stable, extinct hold between done pulses.
- Reset mid-RUN aborts: no done pulse, board_out cleared.
- Degenerate sizes: W or H < 3 with wrap make the same cell count multiple times (e.g. W=1 counts self via both col neighbours); defined, not special-cased. W, H >= 1 required.

Decomposition:
- Package life_pkg holds:
  - Rule constants RULE_B_CONWAY = 9'b000001000, RULE_S_CONWAY = 9'b000001100, RULE_B_HIGHLIFE = 9'b001001000.
  - State enum {IDLE, RUN, FIN}.
  - Function for cell index r*W+c.
- Sub-module life_row_eval, purely combinational: inputs are rows above/current/below (W bits each), B, S, edge_wrap; output is the next row (W bits). The engine instantiates it once and muxes rows by the row counter.

Test Plan:
- Blinker, Conway rule, wrap, 5x5:
  - Start with horizontal blinker at row 2, cols 1-3 -> done exactly 6 cycles after start; vertical blinker at col 2, rows 1-3.
  - stable=0, extinct=0, gen_count=1.
  - Second step restores the horizontal blinker; gen_count=2.
- Glider at board corner, 8x8, 4 steps:
  - edge_wrap=1 -> glider reappears translated (+1,+1) modulo 8.
  - edge_wrap=0 -> glider is clipped; board differs from the wrap result.
- Still life and extinction:
  - 2x2 block -> stable=1, extinct=0, board unchanged.
  - Single live cell -> board all zero, extinct=1, stable=0.
- B0 rule: B=9'b000000001, S=0, empty board -> every cell born; board all ones.
- Handshake:
  - start held high for 3H cycles -> done pulses once per H+2 cycles, never while busy.
  - board_in changed during RUN -> result still computed from the captured board.
- Reset mid-RUN, at row 3:
  - No done pulse; board_out=0, gen_count=0, busy=0.
  - A fresh start completes normally.
